// File: rtl/bnn_conv_engine.sv
// bnn_conv_engine
// Binary 3x3 convolution engine. Once load_done is seen, it walks every filter
// over every valid (unpadded, stride-1) position of the binary image. For each
// position it emits one result beat on a valid/ready interface: the XNOR match
// count and its thresholded bit.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   pixels             IMG x IMG binary image, pixels[row][col]
//   weights            NF binary 3x3 kernels, weights[f][r][c]
//   load_done          image/weights loaded (sticky upstream)
//   out_valid/ready    result handshake
//   out_bit, out_pop   thresholded result and match count (0..9)
//   out_f/row/col      position of the current beat
//   busy, done         engine running / run complete
module bnn_conv_engine #(
    parameter int IMG    = 28,
    parameter int NF     = 8,
    parameter int THRESH = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [IMG-1:0][IMG-1:0]   pixels,
    input  logic [NF-1:0][2:0][2:0]   weights,
    input  logic                      load_done,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_bit,
    output logic [3:0]                out_pop,
    output logic [2:0]                out_f,
    output logic [4:0]                out_row,
    output logic [4:0]                out_col,
    output logic                      busy,
    output logic                      done
);
    localparam int         OUT    = IMG - 2;
    localparam int         IW     = $clog2(IMG);
    localparam logic [4:0] POS_LAST = 5'(OUT - 1);
    localparam logic [2:0] F_LAST   = 3'(NF - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t       state_q, state_d;
    logic [2:0]   f_q, f_d;
    logic [4:0]   i_q, i_d;
    logic [4:0]   j_q, j_d;
    logic         more_q, more_d;       // a position is still waiting to be loaded
    logic         vld_q, vld_d;
    logic         bit_q, bit_d;
    logic [3:0]   pop_q, pop_d;
    logic [2:0]   of_q, of_d;
    logic [4:0]   orow_q, orow_d;
    logic [4:0]   ocol_q, ocol_d;

    logic [8:0]   win;
    logic [8:0]   ker;
    logic [3:0]   win_pop;

    function automatic logic [3:0] match_count(input logic [8:0] w, input logic [8:0] k);
        logic [3:0] cnt;
        cnt = '0;
        for (int n = 0; n < 9; n++) begin
            cnt = cnt + {3'b000, ~(w[4'(n)] ^ k[4'(n)])};
        end
        return cnt;
    endfunction

    function automatic logic binarise(input logic [3:0] pop);
        return pop >= 4'(THRESH);
    endfunction

    // Window gather: the counters always point at the next position to load
    always_comb begin
        win = '0;
        ker = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win[4'(r*3 + c)] = pixels[IW'(int'(i_q) + r)][IW'(int'(j_q) + c)];
                ker[4'(r*3 + c)] = weights[f_q][2'(r)][2'(c)];
            end
        end
        win_pop = match_count(win, ker);
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        i_d     = i_q;
        j_d     = j_q;
        more_d  = more_q;
        vld_d   = vld_q;
        bit_d   = bit_q;
        pop_d   = pop_q;
        of_d    = of_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        case (state_q)
            S_IDLE: begin
                if (load_done) state_d = S_RUN;
            end
            S_RUN: begin
                // Output register is free (empty or being drained) and work remains
                if (more_q && (!vld_q || out_ready)) begin
                    vld_d  = 1'b1;
                    pop_d  = win_pop;
                    bit_d  = binarise(win_pop);
                    of_d   = f_q;
                    orow_d = i_q;
                    ocol_d = j_q;
                    if (j_q == POS_LAST) begin
                        j_d = '0;
                        if (i_q == POS_LAST) begin
                            i_d = '0;
                            if (f_q == F_LAST) more_d = 1'b0;
                            else               f_d    = f_q + 3'd1;
                        end else begin
                            i_d = i_q + 5'd1;
                        end
                    end else begin
                        j_d = j_q + 5'd1;
                    end
                end else if (vld_q && out_ready) begin
                    // Only reachable with nothing left to load: this is the final beat
                    vld_d = 1'b0;
                    if (!more_q) state_d = S_DONE;
                end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase
    end

    // Result register stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            more_q  <= 1'b1;
            vld_q   <= 1'b0;
            bit_q   <= 1'b0;
            pop_q   <= '0;
            of_q    <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            i_q     <= i_d;
            j_q     <= j_d;
            more_q  <= more_d;
            vld_q   <= vld_d;
            bit_q   <= bit_d;
            pop_q   <= pop_d;
            of_q    <= of_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
        end
    end

    assign out_valid = vld_q;
    assign out_bit   = bit_q;
    assign out_pop   = pop_q;
    assign out_f     = of_q;
    assign out_row   = orow_q;
    assign out_col   = ocol_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
endmodule

// File: tb/tb_bnn_conv_engine.sv
module tb_bnn_conv_engine;
    localparam int NBEAT = 5408;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [27:0][27:0]    pixels;
    logic [7:0][2:0][2:0] weights;
    logic                 load_done;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_bit;
    logic [3:0]           out_pop;
    logic [2:0]           out_f;
    logic [4:0]           out_row;
    logic [4:0]           out_col;
    logic                 busy;
    logic                 done;

    bnn_conv_engine #(.IMG(28), .NF(8), .THRESH(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pixels    (pixels),
        .weights   (weights),
        .load_done (load_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_pop   (out_pop),
        .out_f     (out_f),
        .out_row   (out_row),
        .out_col   (out_col),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0] cap_pop [NBEAT];
    logic       cap_bit [NBEAT];

    // mode 0: pixels 1 / weights 1; mode 1: pixels 1 / weights 0; mode 2: checkerboard
    typedef struct {
        int mode;
        int f;
        int row;
        int col;
        int pop;
        int bt;
    } vec_t;

    localparam int NVEC = 19;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, int'({out_valid, out_bit, out_pop, out_f, out_row, out_col, busy, done}), 0);
    endtask

    task automatic setup(input int mode);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                pixels[r][c] = (mode == 2) ? (((r + c) % 2) == 1) : 1'b1;
        if (mode == 0) weights = '1;
        else           weights = '0;
        if (mode == 2) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    weights[0][r][c] = (((r + c) % 2) == 1);
                    weights[1][r][c] = 1'b1;
                    weights[4][r][c] = (((r + c) % 2) == 0);
                end
            end
            weights[3][1][1] = 1'b1;
        end
    endtask

    // Called at posedge+1; leaves the DUT idle at posedge+1 with reset released
    task automatic do_reset();
        reset_n   = 1'b0;
        load_done = 1'b0;
        out_ready = 1'b0;
        #2;
        chk_zero("reset_outs");
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic start_run();
        load_done = 1'b1;
        @(posedge clk); #1;
        chk("enter_run_busy", busy, 1);
        chk("enter_run_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("first_valid", out_valid, 1);
    endtask

    task automatic capture(input int mode, input bit stall, input int abort_at, output int nbeat);
        int   n    = 0;
        int   cyc  = 0;
        bit   held = 0;
        logic [17:0] saved = '0;
        int   exp_pos;
        while (n < NBEAT && cyc < 30000) begin
            if (held) begin
                chk("stall_hold", int'({out_bit, out_pop, out_f, out_row, out_col}), int'(saved));
                chk("stall_hold_valid", out_valid, 1);
                held = 0;
            end
            if (abort_at > 0 && n == abort_at) break;
            if (n == 10) load_done = 1'b0;
            out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!stall) chk("no_bubble", out_valid, 1);
            if (out_valid && out_ready) begin
                exp_pos = (n / 676) * 10000 + ((n / 26) % 26) * 100 + (n % 26);
                chk("beat_order", int'(out_f) * 10000 + int'(out_row) * 100 + int'(out_col), exp_pos);
                cap_pop[n] = out_pop;
                cap_bit[n] = out_bit;
                if (mode == 0) chk("all_ones_beat", int'({out_pop, out_bit}), int'({4'd9, 1'b1}));
                if (mode == 1) chk("all_zero_w_beat", int'({out_pop, out_bit}), 0);
                n++;
            end else if (out_valid) begin
                held  = 1;
                saved = {out_bit, out_pop, out_f, out_row, out_col};
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 30000) chk("capture_timeout", 1, 0);
        if (abort_at == 0) begin
            chk("beat_total", n, NBEAT);
            chk("end_valid", out_valid, 0);
            chk("end_done", done, 1);
            chk("end_busy", busy, 0);
        end
        nbeat = n;
    endtask

    task automatic apply_table(input int mode);
        int idx;
        for (int k = 0; k < NVEC; k++) begin
            if (tbl[k].mode == mode) begin
                idx = tbl[k].f * 676 + tbl[k].row * 26 + tbl[k].col;
                chk($sformatf("vec%0d_pop", k), int'(cap_pop[idx]), tbl[k].pop);
                chk($sformatf("vec%0d_bit", k), int'(cap_bit[idx]), tbl[k].bt);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;

        tbl[0]  = '{0, 0,  0,  0, 9, 1};
        tbl[1]  = '{0, 3, 12, 20, 9, 1};
        tbl[2]  = '{0, 7, 25, 25, 9, 1};
        tbl[3]  = '{1, 0,  0,  0, 0, 0};
        tbl[4]  = '{1, 7, 25, 25, 0, 0};
        tbl[5]  = '{2, 0,  0,  0, 9, 1};
        tbl[6]  = '{2, 0,  0,  1, 0, 0};
        tbl[7]  = '{2, 0,  1,  0, 0, 0};
        tbl[8]  = '{2, 0, 25, 25, 9, 1};
        tbl[9]  = '{2, 0,  3,  4, 0, 0};
        tbl[10] = '{2, 1,  0,  0, 4, 0};
        tbl[11] = '{2, 1,  0,  1, 5, 1};
        tbl[12] = '{2, 2,  0,  0, 5, 1};
        tbl[13] = '{2, 2,  7,  8, 4, 0};
        tbl[14] = '{2, 3,  0,  0, 4, 0};
        tbl[15] = '{2, 3,  0,  1, 5, 1};
        tbl[16] = '{2, 4,  0,  0, 0, 0};
        tbl[17] = '{2, 4, 10, 11, 9, 1};
        tbl[18] = '{2, 7, 25, 25, 5, 1};

        reset_n   = 1'b0;
        load_done = 1'b0;
        out_ready = 1'b0;
        setup(0);
        #3;
        chk_zero("reset_state");
        @(posedge clk); #1;
        chk_zero("reset_held");
        reset_n = 1'b1;

        // Idle with load_done low
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            chk("idle_valid", out_valid, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end

        // All ones, full throughput; load_done drops mid-run
        start_run();
        capture(0, 1'b0, 0, nb);
        apply_table(0);
        load_done = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("done_hold_valid", out_valid, 0);
            chk("done_hold_done", done, 1);
            chk("done_hold_busy", busy, 0);
        end

        // All pixels 1, all weights 0
        setup(1);
        do_reset();
        start_run();
        capture(1, 1'b0, 0, nb);
        apply_table(1);

        // Checkerboard, full throughput
        setup(2);
        do_reset();
        start_run();
        capture(2, 1'b0, 0, nb);
        apply_table(2);

        // Checkerboard with random back-pressure
        do_reset();
        start_run();
        capture(2, 1'b1, 0, nb);
        apply_table(2);

        // Reset in the middle of a run, then restart
        setup(0);
        do_reset();
        start_run();
        capture(0, 1'b0, 1000, nb);
        chk("abort_beats", nb, 1000);
        #2;
        reset_n   = 1'b0;
        load_done = 1'b1;
        #1;
        chk_zero("abort_reset");
        @(posedge clk); #1;
        chk_zero("abort_reset_edge");
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("restart_busy", busy, 1);
        chk("restart_valid_early", out_valid, 0);
        @(posedge clk); #1;
        chk("restart_valid", out_valid, 1);
        chk("restart_pos", int'({out_f, out_row, out_col}), 0);
        chk("restart_pop", int'(out_pop), 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
